// File: rtl/sha256_compress_core.sv
// Iterative SHA-256 compression core: one round per clock, 16-word rolling
// message schedule, hash chaining across blocks and a streamed 8-word digest.
module sha256_compress_core #(
  parameter bit IV_CHAIN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic [5:0]  k_addr,
  input  logic [31:0] k_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);

  localparam int unsigned WORD_W = 32;

  localparam logic [WORD_W-1:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  typedef enum logic [1:0] {S_LOAD, S_ROUND, S_FINAL, S_OUT} state_t;

  function automatic logic [WORD_W-1:0] bsig0(input logic [WORD_W-1:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [WORD_W-1:0] bsig1(input logic [WORD_W-1:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [WORD_W-1:0] ssig0(input logic [WORD_W-1:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] ssig1(input logic [WORD_W-1:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [5:0]        rnd_q, rnd_d;
  logic [2:0]        idx_q, idx_d;
  logic              last_q, last_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;
  logic [WORD_W-1:0] h_q [8];
  logic [WORD_W-1:0] h_d [8];
  logic [WORD_W-1:0] wv_q [8];
  logic [WORD_W-1:0] wv_d [8];
  logic [WORD_W-1:0] w_q [16];
  logic [WORD_W-1:0] w_d [16];

  // Round datapath: schedule word, T1/T2 for the current round index
  logic [3:0]        it, i2, i7, i15;
  logic [WORD_W-1:0] w_new, wt, ch, maj, t1, t2;

  always_comb begin
    it    = rnd_q[3:0];
    i2    = it - 4'd2;
    i7    = it - 4'd7;
    i15   = it + 4'd1;
    w_new = ssig1(w_q[i2]) + w_q[i7] + ssig0(w_q[i15]) + w_q[it];
    wt    = (rnd_q[5:4] == 2'd0) ? w_q[it] : w_new;
    ch    = (wv_q[4] & wv_q[5]) ^ (~wv_q[4] & wv_q[6]);
    maj   = (wv_q[0] & wv_q[1]) ^ (wv_q[0] & wv_q[2]) ^ (wv_q[1] & wv_q[2]);
    t1    = wv_q[7] + bsig1(wv_q[4]) + ch + k_data + wt;
    t2    = bsig0(wv_q[0]) + maj;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rnd_d      = rnd_q;
    idx_d      = idx_q;
    last_d     = last_q;
    out_data_d = out_data_q;
    h_d        = h_q;
    wv_d       = wv_q;
    w_d        = w_q;

    case (state_q)
      S_LOAD: begin
        if (in_valid && in_ready_q) begin
          w_d[cnt_q] = in_data;
          cnt_d      = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            last_d  = in_last;
            wv_d    = h_q;
            rnd_d   = 6'd0;
            state_d = S_ROUND;
          end
        end
      end
      S_ROUND: begin
        rnd_d = rnd_q + 6'd1;
        if (rnd_q[5:4] != 2'd0) w_d[it] = w_new;
        wv_d[0] = t1 + t2;
        wv_d[1] = wv_q[0];
        wv_d[2] = wv_q[1];
        wv_d[3] = wv_q[2];
        wv_d[4] = wv_q[3] + t1;
        wv_d[5] = wv_q[4];
        wv_d[6] = wv_q[5];
        wv_d[7] = wv_q[6];
        if (rnd_q == 6'd63) state_d = S_FINAL;
      end
      S_FINAL: begin
        for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + wv_q[i];
        if (last_q) begin
          idx_d      = 3'd0;
          out_data_d = h_q[0] + wv_q[0];
          state_d    = S_OUT;
        end else begin
          state_d = S_LOAD;
        end
        last_d = 1'b0;
      end
      S_OUT: begin
        if (out_valid_q && out_ready) begin
          if (idx_q == 3'd7) begin
            if (IV_CHAIN) h_d = IV;
            idx_d      = 3'd0;
            out_data_d = '0;
            state_d    = S_LOAD;
          end else begin
            idx_d      = idx_q + 3'd1;
            out_data_d = h_q[3'(idx_q + 3'd1)];
          end
        end
      end
      default: state_d = S_LOAD;
    endcase

    in_ready_d  = (state_d == S_LOAD);
    out_valid_d = (state_d == S_OUT);
    busy_d      = (state_d != S_LOAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_LOAD;
      cnt_q       <= 4'd0;
      rnd_q       <= 6'd0;
      idx_q       <= 3'd0;
      last_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      out_data_q  <= '0;
      h_q         <= IV;
      for (int i = 0; i < 8; i++) wv_q[i] <= '0;
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rnd_q       <= rnd_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      out_data_q  <= out_data_d;
      h_q         <= h_d;
      wv_q        <= wv_d;
      w_q         <= w_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  // The round counter is zero outside ROUND, so it doubles as the ROM address
  assign k_addr    = rnd_q;

endmodule

// File: tb/tb_sha256_compress_core.sv
// Self-checking bench for sha256_compress_core: known vectors, latency,
// backpressure, mid-round reset and random messages against a reference model.
module tb_sha256_compress_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic [5:0]  k_addr;
  logic [31:0] k_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  assign k_data = K_ROM[k_addr];

  always #5 clk = ~clk;

  sha256_compress_core #(.IV_CHAIN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .k_addr(k_addr), .k_data(k_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  logic [31:0] blk [16];
  logic [31:0] exp_h [8];
  logic [31:0] mh [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: textbook SHA-256 compression on a full 64-word schedule
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic model_block();
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, s1, s0, t1, t2;
    for (int t = 0; t < 16; t++) w[t] = blk[t];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    a = mh[0]; b = mh[1]; c = mh[2]; d = mh[3];
    e = mh[4]; f = mh[5]; g = mh[6]; h = mh[7];
    for (int t = 0; t < 64; t++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K_ROM[t] + w[t];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
    end
    mh[0] += a; mh[1] += b; mh[2] += c; mh[3] += d;
    mh[4] += e; mh[5] += f; mh[6] += g; mh[7] += h;
  endtask

  task automatic set_exp(input logic [255:0] v);
    for (int i = 0; i < 8; i++) exp_h[i] = v[255 - 32*i -: 32];
  endtask

  task automatic load_abc();
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
  endtask

  task automatic load_empty();
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0] = 32'h80000000;
  endtask

  task automatic load_two1();
    logic [7:0] c0;
    for (int i = 0; i < 14; i++) begin
      c0 = 8'(8'h61 + i);
      blk[i] = {c0, c0 + 8'd1, c0 + 8'd2, c0 + 8'd3};
    end
    blk[14] = 32'h80000000;
    blk[15] = 32'h0;
  endtask

  task automatic load_two2();
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[15] = 32'h000001c0;
  endtask

  // Feeds blk[] then follows the block through ROUND/FINAL with latency checks
  task automatic send_block(input string name, input bit last, input bit gaps, input int abort_round);
    int guard;
    bit stray;
    for (int i = 0; i < 16; i++) begin
      if (gaps) begin
        int g = int'($urandom_range(0, 2));
        in_valid = 1'b0;
        repeat (g) tick();
      end
      in_valid = 1'b1;
      in_data  = blk[i];
      in_last  = (i == 15) ? last : 1'($urandom_range(0, 1));
      guard = 0;
      while (!in_ready && guard < 200) begin
        tick();
        guard++;
      end
      if (!in_ready) begin
        check({name, "_load_timeout"}, 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        return;
      end
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check({name, "_ready_drop"}, 32'(in_ready), 32'd0);
    check({name, "_kaddr_t0"}, 32'(k_addr), 32'd0);
    check({name, "_busy_round"}, 32'(busy), 32'd1);
    stray = 1'b0;
    for (int c = 1; c <= 65; c++) begin
      tick();
      if (abort_round > 0 && c == abort_round) begin
        check({name, "_kaddr_abort"}, 32'(k_addr), 32'(abort_round));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check({name, "_rst_ready"}, 32'(in_ready), 32'd1);
        check({name, "_rst_valid"}, 32'(out_valid), 32'd0);
        check({name, "_rst_busy"}, 32'(busy), 32'd0);
        check({name, "_rst_kaddr"}, 32'(k_addr), 32'd0);
        for (int j = 0; j < 70; j++) begin
          tick();
          if (out_valid) stray = 1'b1;
        end
        check({name, "_rst_stray_valid"}, 32'(stray), 32'd0);
        return;
      end
      if (c < 65 && out_valid) stray = 1'b1;
      if (c == 63) check({name, "_kaddr_t63"}, 32'(k_addr), 32'd63);
      if (c == 64) begin
        check({name, "_final_valid"}, 32'(out_valid), 32'd0);
        check({name, "_final_kaddr"}, 32'(k_addr), 32'd0);
      end
      if (c == 65) begin
        if (last) begin
          check({name, "_lat_valid"}, 32'(out_valid), 32'd1);
        end else begin
          check({name, "_lat_ready"}, 32'(in_ready), 32'd1);
          check({name, "_lat_novalid"}, 32'(out_valid), 32'd0);
          check({name, "_lat_idle"}, 32'(busy), 32'd0);
        end
      end
    end
    check({name, "_stray_valid"}, 32'(stray), 32'd0);
  endtask

  // Collects 8 digest words; mode 0 always ready, 1 pattern 1,0,0, 2 random
  task automatic recv_digest(input string name, input int mode);
    logic [31:0] rx [8];
    logic [31:0] prev_data;
    bit prev_hold;
    bit r;
    int got, guard, ph;
    got = 0; guard = 0; ph = 0; prev_hold = 1'b0; prev_data = '0;
    for (int i = 0; i < 8; i++) rx[i] = '0;
    while (got < 8 && guard < 300) begin
      if (out_valid && prev_hold)
        check({name, "_hold_stable"}, out_data, prev_data);
      case (mode)
        0:       r = 1'b1;
        1:       r = (ph % 3 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      ph++;
      out_ready = r;
      if (out_valid && r) begin
        rx[got] = out_data;
        got++;
        prev_hold = 1'b0;
      end else begin
        prev_hold = out_valid;
      end
      prev_data = out_data;
      tick();
      guard++;
    end
    check({name, "_word_count"}, 32'(got), 32'd8);
    check({name, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({name, "_ready_back"}, 32'(in_ready), 32'd1);
    tick();
    check({name, "_no_extra"}, 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++)
      check($sformatf("%s_h%0d", name, i), rx[i], exp_h[i]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_k_addr", 32'(k_addr), 32'd0);
    check("reset_out_data", out_data, 32'd0);
    tick();
    check("idle_no_accept", 32'(busy), 32'd0);

    set_exp(256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad);
    load_abc();
    send_block("abc", 1'b1, 1'b0, 0);
    recv_digest("abc", 0);

    set_exp(256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855);
    load_empty();
    send_block("empty", 1'b1, 1'b0, 0);
    recv_digest("empty_bp", 1);

    set_exp(256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1);
    load_two1();
    send_block("two_b1", 1'b0, 1'b0, 0);
    load_two2();
    send_block("two_b2", 1'b1, 1'b0, 0);
    recv_digest("two", 0);

    set_exp(256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad);
    load_abc();
    send_block("abc_gaps", 1'b1, 1'b1, 0);
    recv_digest("abc_gaps", 2);

    load_abc();
    send_block("abc_abort", 1'b1, 1'b0, 30);
    load_abc();
    send_block("abc_resend", 1'b1, 1'b0, 0);
    recv_digest("abc_resend", 0);

    load_abc();
    send_block("b2b_abc", 1'b1, 1'b0, 0);
    recv_digest("b2b_abc", 0);
    set_exp(256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855);
    load_empty();
    send_block("b2b_empty", 1'b1, 1'b0, 0);
    recv_digest("b2b_empty", 0);

    for (int m = 0; m < 3; m++) begin
      int nblk = int'($urandom_range(1, 2));
      for (int i = 0; i < 8; i++) mh[i] = IV[i];
      for (int b = 0; b < nblk; b++) begin
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
        model_block();
        send_block($sformatf("rnd%0d_b%0d", m, b), 1'(b == nblk - 1), 1'b1, 0);
      end
      for (int i = 0; i < 8; i++) exp_h[i] = mh[i];
      recv_digest($sformatf("rnd%0d", m), 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
